// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory port, redirect request and the decode handshake.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_unit_if;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        fetch_fault_o;

    modport master (
        output imem_addr_o,
        input  imem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output instr_pc_o,
        output fetch_fault_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  instr_pc_o,
        input  fetch_fault_o
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, captures combinational imem data into a small
// prefetch queue and hands {pc, instr, fault} to decode; redirects flush the queue.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] MEM_LIMIT = 32'd4095
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    instr_fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    entry_t        q [DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc;
    logic          halted;
    logic          fault, nonempty, full, push, pop;

    assign fault    = (fetch_pc[1:0] != 2'b00) || (fetch_pc > MEM_LIMIT);
    assign nonempty = (count != '0);
    assign full     = (count == CW'(DEPTH));

    assign bus.imem_addr_o   = fetch_pc;
    assign bus.instr_valid_o = nonempty && !bus.redirect_i;
    assign pop               = bus.instr_valid_o && bus.instr_ready_i;
    // A pop frees the slot in the same cycle, so a full queue keeps streaming.
    assign push              = !bus.redirect_i && !halted && (!full || pop);

    // Empty queue presents zeros so reset/flush never expose stale storage.
    assign head              = nonempty ? q[rd_ptr] : '0;
    assign bus.instr_o       = head.instr;
    assign bus.instr_pc_o    = head.pc;
    assign bus.fetch_fault_o = head.fault;

    always_ff @(posedge clk_i) begin
        if (push) begin
            q[wr_ptr] <= '{pc: fetch_pc, instr: fault ? 32'h0 : bus.imem_rdata_i, fault: fault};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_i) begin
            fetch_pc <= bus.redirect_pc_i;
            halted   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                // A faulted fetch parks the PC on the offending address until redirect.
                if (fault) halted   <= 1'b1;
                else       fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random redirect/ready/reset
// traffic, compared each cycle against a queue-based reference model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] MEM_LIMIT = 32'd4095;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halt;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .MEM_LIMIT(MEM_LIMIT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a <= MEM_LIMIT) ? 32'hA000_0000 + (a >> 2) : {a[15:0], 16'hBEEF};
    endfunction

    assign bus.imem_rdata_i = mem_word(bus.imem_addr_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = RESET_PC;
        m_halt = 1'b0;
    endtask

    // One clock cycle: drive inputs after the edge, compare mid-cycle, advance model.
    task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
        bit   exp_v, do_pop, do_push;
        ent_t e;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.instr_ready_i = rdy;
        #4;
        exp_v = (mq.size() != 0) && !rd;
        chk("imem_addr", bus.imem_addr_o, m_pc);
        chk("valid", 32'(bus.instr_valid_o), 32'(exp_v));
        if (exp_v) begin
            chk("head_pc", bus.instr_pc_o, mq[0].pc);
            chk("head_instr", bus.instr_o, mq[0].instr);
            chk("head_fault", 32'(bus.fetch_fault_o), 32'(mq[0].fault));
        end
        if (rd) begin
            mq.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            do_pop  = exp_v && rdy;
            do_push = !m_halt && (mq.size() < DEPTH || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc    = m_pc;
                e.fault = (m_pc[1:0] != 2'b00) || (m_pc > MEM_LIMIT);
                e.instr = e.fault ? 32'h0 : mem_word(m_pc);
                mq.push_back(e);
                if (e.fault) m_halt = 1'b1;
                else         m_pc   = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy);
    endtask

    // Assert reset between edges and check it bites without waiting for a clock.
    task automatic async_reset();
        #2;
        rst_n             = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.instr_ready_i = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.instr_valid_o), 32'h0);
        chk("rst_addr", bus.imem_addr_o, RESET_PC);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_pc", bus.instr_pc_o, 32'h0);
        chk("rst_fault", 32'(bus.fetch_fault_o), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 5))
            0:       t = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            1:       t = 32'hFF0 + 32'($urandom_range(0, 5)) * 32'd4;
            2:       t = 32'($urandom_range(0, 4095));
            3:       t = $urandom;
            4:       t = 32'hFFFF_FFF8;
            default: t = MEM_LIMIT - 32'd3;
        endcase
        return t;
    endfunction

    initial begin
        n_chk             = 0;
        n_err             = 0;
        rst_n             = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.instr_ready_i = 1'b0;
        model_reset();
        #1;
        chk("reset_valid", 32'(bus.instr_valid_o), 32'h0);
        chk("reset_addr", bus.imem_addr_o, RESET_PC);
        chk("reset_instr", bus.instr_o, 32'h0);
        chk("reset_pc", bus.instr_pc_o, 32'h0);
        chk("reset_fault", 32'(bus.fetch_fault_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming at full rate.
        steps(8, 1'b1);

        // Backpressure from a fresh reset, then drain.
        async_reset();
        steps(6, 1'b0);
        steps(6, 1'b1);

        // Redirect while full and ready is high.
        steps(3, 1'b0);
        step(1'b1, 32'h100, 1'b1);
        steps(5, 1'b1);

        // Misaligned target halts; a clean redirect resumes.
        step(1'b1, 32'h102, 1'b1);
        steps(12, 1'b1);
        step(1'b1, 32'h0, 1'b1);
        steps(4, 1'b1);

        // Running off the end of instruction memory.
        step(1'b1, 32'hFF8, 1'b1);
        steps(6, 1'b1);

        // Asynchronous reset with a full queue.
        step(1'b1, 32'h40, 1'b0);
        steps(3, 1'b0);
        async_reset();
        steps(6, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else if ($urandom_range(0, 15) == 0) begin
                step(1'b1, rand_target(), 1'($urandom_range(0, 1)));
            end else begin
                step(1'b0, 32'h0, $urandom_range(0, 3) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
